// File: rtl/sort_pkg.sv
// Shared types for the bubble-sort engine: FSM state encoding and default widths.
// Kept separate so a future multi-lane sorter can reuse the same state names.
package sort_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int STATE_W    = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 4'd0,
    S_RD_A     = 4'd1,
    S_RD_B     = 4'd2,
    S_CMP      = 4'd3,
    S_WR_A     = 4'd4,
    S_WR_B     = 4'd5,
    S_PASS_END = 4'd6,
    S_DONE     = 4'd7
  } sort_state_t;

  function automatic logic is_rd_state(input sort_state_t s);
    return (s == S_RD_A) || (s == S_RD_B);
  endfunction

  function automatic logic is_wr_state(input sort_state_t s);
    return (s == S_WR_A) || (s == S_WR_B);
  endfunction

  // Second word of the current pair lives at base+j+1.
  function automatic logic is_hi_state(input sort_state_t s);
    return (s == S_RD_B) || (s == S_WR_B);
  endfunction

endpackage

// File: rtl/sort_engine_if.sv
// Single-port memory request bus: the sorter is master, memory answers with a same-cycle rdy.
// A request (rd or wr) holds address/data until rdy is seen.
interface sort_engine_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdy;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_rdy
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_rdy
  );

endinterface

// File: rtl/sort_cmp.sv
// Combinational swap decision for one pair, unsigned; equal words never swap.
// Zero latency, no handshake.
module sort_cmp #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              descend_i,
  output logic              swap_o
);

  assign swap_o = descend_i ? (a_i < b_i) : (a_i > b_i);

endmodule

// File: rtl/sort_engine.sv
// In-place bubble sort over a single-port memory with early exit on a swap-free pass.
// Each access waits on mem_rdy; outputs decode from registered state only.
module sort_engine
  import sort_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = 2 * ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              descend,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  sort_engine_if.master     mem,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  swap_count
);

  localparam logic [ADDR_W:0]   IDX_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   IDX_TWO  = (ADDR_W+1)'(2);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  sort_state_t       state_q,   state_d;
  logic              desc_q,    desc_d;
  logic [ADDR_W-1:0] base_q,    base_d;
  logic [ADDR_W:0]   len_q,     len_d;
  logic [ADDR_W:0]   j_q,       j_d;
  logic [ADDR_W:0]   pass_q,    pass_d;
  logic              swapped_q, swapped_d;
  logic [DATA_W-1:0] a_q,       a_d;
  logic [DATA_W-1:0] b_q,       b_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  logic              swap;
  logic              last_pair;
  logic [ADDR_W-1:0] addr_lo;
  logic [ADDR_W-1:0] addr_hi;

  sort_cmp #(.DATA_W(DATA_W)) u_cmp (
    .a_i      (a_q),
    .b_i      (b_q),
    .descend_i(desc_q),
    .swap_o   (swap)
  );

  // Pass p settles the word at index len-1-p, so its last pair ends there.
  assign last_pair = ((j_q + IDX_ONE) == (len_q - IDX_ONE - pass_q));
  assign addr_lo   = base_q + j_q[ADDR_W-1:0];
  assign addr_hi   = addr_lo + ADDR_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      desc_q    <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      j_q       <= '0;
      pass_q    <= '0;
      swapped_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      desc_q    <= desc_d;
      base_q    <= base_d;
      len_q     <= len_d;
      j_q       <= j_d;
      pass_q    <= pass_d;
      swapped_q <= swapped_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    desc_d    = desc_q;
    base_d    = base_q;
    len_d     = len_q;
    j_d       = j_q;
    pass_d    = pass_q;
    swapped_d = swapped_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          desc_d    = descend;
          base_d    = base_addr;
          len_d     = len;
          cnt_d     = '0;
          j_d       = '0;
          pass_d    = '0;
          swapped_d = 1'b0;
          state_d   = (len <= IDX_ONE) ? S_DONE : S_RD_A;
        end
      end
      S_RD_A: begin
        if (mem.mem_rdy) begin
          a_d     = mem.mem_rdata;
          state_d = S_RD_B;
        end
      end
      S_RD_B: begin
        if (mem.mem_rdy) begin
          b_d     = mem.mem_rdata;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (swap) begin
          state_d = S_WR_A;
        end else if (last_pair) begin
          state_d = S_PASS_END;
        end else begin
          j_d     = j_q + IDX_ONE;
          state_d = S_RD_A;
        end
      end
      S_WR_A: begin
        if (mem.mem_rdy) state_d = S_WR_B;
      end
      S_WR_B: begin
        if (mem.mem_rdy) begin
          swapped_d = 1'b1;
          cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          if (last_pair) begin
            state_d = S_PASS_END;
          end else begin
            j_d     = j_q + IDX_ONE;
            state_d = S_RD_A;
          end
        end
      end
      S_PASS_END: begin
        if (!swapped_q || (pass_q == len_q - IDX_TWO)) begin
          state_d = S_DONE;
        end else begin
          pass_d    = pass_q + IDX_ONE;
          j_d       = '0;
          swapped_d = 1'b0;
          state_d   = S_RD_A;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset forces state_q to IDLE asynchronously, which drops any pending request.
  always_comb begin
    mem.mem_rd    = is_rd_state(state_q);
    mem.mem_wr    = is_wr_state(state_q);
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (is_rd_state(state_q) || is_wr_state(state_q)) begin
      mem.mem_addr = is_hi_state(state_q) ? addr_hi : addr_lo;
    end
    if (state_q == S_WR_A) mem.mem_wdata = b_q;
    if (state_q == S_WR_B) mem.mem_wdata = a_q;
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign swap_count = cnt_q;

endmodule

// File: tb/tb_sort_engine.sv
// Directed + randomized bench for sort_engine against a sorted-queue / inversion-count reference.
module tb_sort_engine;

  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int CW     = 8;
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          descend;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [CW-1:0] swap_count;

  always #5 clk = ~clk;

  sort_engine_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  sort_engine #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .descend   (descend),
    .base_addr (base_addr),
    .len       (len),
    .mem       (mif),
    .busy      (busy),
    .done      (done),
    .swap_count(swap_count)
  );

  // Memory model with optional random rdy stalls
  logic [DW-1:0] tb_mem [16];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_dat = '0;
  bit            stall_en = 1'b0;
  int            wait_left = 0;

  assign mif.mem_rdata = tb_mem[mif.mem_addr];
  assign mif.mem_rdy   = (wait_left == 0);

  always @(posedge clk) begin
    if (ld_en) tb_mem[ld_addr] <= ld_dat;
    else if (mif.mem_wr && mif.mem_rdy) tb_mem[mif.mem_addr] <= mif.mem_wdata;
    if ((mif.mem_rd || mif.mem_wr) && mif.mem_rdy)
      wait_left <= stall_en ? int'($urandom_range(4, 0)) : 0;
    else if ((mif.mem_rd || mif.mem_wr) && wait_left > 0)
      wait_left <= wait_left - 1;
  end

  // Bus monitor, sampled mid-cycle
  int            rd_cnt = 0, wr_cnt = 0, both_err = 0, stab_err = 0, done_cnt = 0;
  int            touched [16];
  int            run_id = 0;
  bit            pend = 1'b0;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic          p_rd;

  always @(negedge clk) begin
    if (mif.mem_rd && mif.mem_wr) both_err++;
    if (done) done_cnt++;
    if (mif.mem_rd || mif.mem_wr) begin
      touched[mif.mem_addr] = run_id;
      if (pend && (mif.mem_addr !== p_addr || mif.mem_wdata !== p_wdata || mif.mem_rd !== p_rd))
        stab_err++;
      if (mif.mem_rdy) begin
        if (mif.mem_rd) rd_cnt++;
        else wr_cnt++;
      end
    end
    pend    = (mif.mem_rd || mif.mem_wr) && !mif.mem_rdy;
    p_addr  = mif.mem_addr;
    p_wdata = mif.mem_wdata;
    p_rd    = mif.mem_rd;
  end

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] img [16];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic rand_img();
    for (int a = 0; a < 16; a++) img[a] = 8'($urandom_range(255, 0));
  endtask

  task automatic load_img();
    for (int a = 0; a < 16; a++) begin
      ld_en   = 1'b1;
      ld_addr = a[AW-1:0];
      ld_dat  = img[a];
      tick();
    end
    ld_en = 1'b0;
  endtask

  task automatic run_sort(input bit d, input int b, input int n, output int cyc, output logic lb);
    tick();
    start     = 1'b1;
    descend   = d;
    base_addr = AW'(b);
    len       = (AW+1)'(n);
    cyc       = 1;
    lb        = 1'b0;
    tick();
    start = 1'b0;
    cyc   = 2;
    while (!done && cyc < BUDGET) begin
      lb = busy;
      tick();
      cyc++;
    end
    if (!done) check("done timeout", {31'd0, done}, 32'd1);
    else check("busy at done", {31'd0, busy}, 32'd0);
  endtask

  // Reference: the n words from base (wrapping) end up fully sorted; swaps = strict inversions.
  task automatic verify(input string tag, input bit d, input int b, input int n);
    logic [DW-1:0] q [$];
    logic [DW-1:0] exp_img [16];
    int            inv;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(img[(b + i) % 16]);
    inv = 0;
    for (int i = 0; i < n; i++)
      for (int k = i + 1; k < n; k++)
        if (d ? (q[i] < q[k]) : (q[i] > q[k])) inv++;
    if (d) q.rsort();
    else q.sort();
    exp_img = img;
    for (int i = 0; i < n; i++) exp_img[(b + i) % 16] = q[i];
    for (int a = 0; a < 16; a++)
      check($sformatf("%s mem[%0d]", tag, a), {24'd0, tb_mem[a]}, {24'd0, exp_img[a]});
    check({tag, " swap_count"}, {24'd0, swap_count}, inv);
    img = exp_img;
  endtask

  initial begin
    int   cyc, d0, r0, w0, b, n;
    logic lb;
    bit   d, seen;

    rst_n = 1'b0; start = 1'b0; descend = 1'b0; base_addr = '0; len = '0;
    tick();
    tick();
    check("rst busy", {31'd0, busy}, 0);
    check("rst done", {31'd0, done}, 0);
    check("rst mem_rd", {31'd0, mif.mem_rd}, 0);
    check("rst mem_wr", {31'd0, mif.mem_wr}, 0);
    check("rst mem_addr", {28'd0, mif.mem_addr}, 0);
    check("rst mem_wdata", {24'd0, mif.mem_wdata}, 0);
    check("rst swap_count", {24'd0, swap_count}, 0);
    rst_n = 1'b1;
    tick();

    // Ascending {3,1,2}
    rand_img();
    img[0] = 8'd3; img[1] = 8'd1; img[2] = 8'd2;
    load_img();
    d0 = done_cnt;
    run_sort(1'b0, 0, 3, cyc, lb);
    check("asc3 busy before done", {31'd0, lb}, 1);
    verify("asc3", 1'b0, 0, 3);
    check("asc3 swaps", {24'd0, swap_count}, 2);
    tick();
    check("asc3 done low after", {31'd0, done}, 0);
    check("asc3 done pulses", done_cnt - d0, 1);

    // Already sorted: single pass, no writes
    img[0] = 8'd1; img[1] = 8'd2; img[2] = 8'd3; img[3] = 8'd4;
    load_img();
    r0 = rd_cnt; w0 = wr_cnt;
    run_sort(1'b0, 0, 4, cyc, lb);
    check("sorted4 cycles", cyc, 12);
    check("sorted4 reads", rd_cnt - r0, 6);
    check("sorted4 writes", wr_cnt - w0, 0);
    verify("sorted4", 1'b0, 0, 4);

    // Descending {1,5,2,4,3}
    img[0] = 8'd1; img[1] = 8'd5; img[2] = 8'd2; img[3] = 8'd4; img[4] = 8'd3;
    load_img();
    run_sort(1'b1, 0, 5, cyc, lb);
    verify("desc5", 1'b1, 0, 5);
    check("desc5 swaps", {24'd0, swap_count}, 6);

    // Degenerate lengths
    for (int l = 1; l >= 0; l--) begin
      r0 = rd_cnt; w0 = wr_cnt;
      run_sort(1'b0, 5, l, cyc, lb);
      check($sformatf("len%0d cycles", l), cyc, 2);
      check($sformatf("len%0d accesses", l), (rd_cnt - r0) + (wr_cnt - w0), 0);
      verify($sformatf("len%0d", l), 1'b0, 5, l);
    end

    // Random data with random rdy stalls
    stall_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      rand_img();
      load_img();
      d = 1'($urandom_range(1, 0));
      b = int'($urandom_range(15, 0));
      n = (r == 0) ? 16 : int'($urandom_range(16, 2));
      run_sort(d, b, n, cyc, lb);
      verify($sformatf("stall%0d", r), d, b, n);
    end
    check("stall addr/wdata stable", stab_err, 0);
    stall_en = 1'b0;
    tick();
    tick();

    // Address wrap: base 14, len 4
    rand_img();
    load_img();
    run_id = 1;
    run_sort(1'b0, 14, 4, cyc, lb);
    verify("wrap", 1'b0, 14, 4);
    for (int a = 0; a < 16; a++)
      check($sformatf("wrap touched[%0d]", a), {31'd0, touched[a] == 1},
            {31'd0, (a == 14 || a == 15 || a == 0 || a == 1)});

    // Reset in WR_A
    for (int a = 0; a < 16; a++) img[a] = 8'(a * 10);
    load_img();
    tick();
    start = 1'b1; descend = 1'b1; base_addr = '0; len = 5'd8;
    tick();
    start = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      if (mif.mem_wr) seen = 1'b1;
      else tick();
    end
    check("reached WR_A", {31'd0, mif.mem_wr}, 1);
    rst_n = 1'b0;
    #1;
    check("arst mem_wr", {31'd0, mif.mem_wr}, 0);
    check("arst mem_rd", {31'd0, mif.mem_rd}, 0);
    check("arst busy", {31'd0, busy}, 0);
    check("arst swap_count", {24'd0, swap_count}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post-reset idle", {31'd0, busy}, 0);

    rand_img();
    load_img();
    run_sort(1'b1, 3, 6, cyc, lb);
    verify("after reset", 1'b1, 3, 6);

    check("rd/wr overlap", both_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
